// File: rtl/shake_squeeze_collector.sv
// Collects a runtime-selected number of sponge squeeze words into one wide digest
// and presents it with a valid/ready hold handshake. Optional build macro: SQZ_BYTESWAP_EN.
module shake_squeeze_collector #(
    parameter  int DATA_OUT_BITS   = 32,
    parameter  int MAX_DIGEST_BITS = 512,
    localparam int MAX_WORDS       = MAX_DIGEST_BITS / DATA_OUT_BITS,
    localparam int CNT_W           = $clog2(MAX_WORDS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           len_words,
    input  logic [DATA_OUT_BITS-1:0]   data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [MAX_DIGEST_BITS-1:0] digest,
    output logic                       digest_valid,
    input  logic                       digest_ready,
    output logic                       busy
);

    localparam logic [CNT_W-1:0] MAX_WORDS_C = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HOLD
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [CNT_W-1:0]           r_len;
    logic [CNT_W-1:0]           r_idx;
    logic [MAX_DIGEST_BITS-1:0] r_digest;
    logic [DATA_OUT_BITS-1:0]   w_word;
    logic [CNT_W-1:0]           w_len_sel;
    logic                       w_start_acc;
    logic                       w_hs;
    logic                       w_last;

`ifdef SQZ_BYTESWAP_EN
    for (genvar gi = 0; gi < DATA_OUT_BITS / 8; gi++) begin : g_swap
        assign w_word[gi*8 +: 8] = data_in[DATA_OUT_BITS-8-gi*8 +: 8];
    end
`else
    assign w_word = data_in;
`endif

    // A zero or oversized request means "fill the whole register".
    assign w_len_sel   = (len_words == '0 || len_words > MAX_WORDS_C) ? MAX_WORDS_C : len_words;
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_hs        = (r_state == ST_COLLECT) && in_valid;
    assign w_last      = (r_idx == r_len - CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start)           w_state_next = ST_COLLECT;
            ST_COLLECT: if (w_hs && w_last)  w_state_next = ST_HOLD;
            ST_HOLD:    if (digest_ready)    w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_idx    <= '0;
            r_digest <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start_acc) begin
                r_len    <= w_len_sel;
                r_idx    <= '0;
                r_digest <= '0;
            end else if (w_hs) begin
                r_idx <= r_idx + CNT_W'(1);
                for (int k = 0; k < MAX_WORDS; k++) begin
                    if (r_idx == CNT_W'(k)) begin
                        r_digest[k*DATA_OUT_BITS +: DATA_OUT_BITS] <= w_word;
                    end
                end
            end
        end
    end

    // Handshake outputs decode the state register only, so in_valid never
    // reaches in_ready combinationally.
    assign in_ready     = (r_state == ST_COLLECT);
    assign digest_valid = (r_state == ST_HOLD);
    assign busy         = (r_state != ST_IDLE);
    assign digest       = r_digest;

endmodule

// File: tb/tb_shake_squeeze_collector.sv
// Self-checking bench for shake_squeeze_collector: table-driven randomized transactions
// plus hand-written corner sequences, checked against a queue-based digest model.
module tb_shake_squeeze_collector;

    localparam int DW    = 32;
    localparam int MDB   = 512;
    localparam int MAXW  = MDB / DW;
    localparam int CNT_W = $clog2(MAXW + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len_words;
    logic [DW-1:0]    data_in;
    logic             in_valid;
    logic             in_ready;
    logic [MDB-1:0]   digest;
    logic             digest_valid;
    logic             digest_ready;
    logic             busy;

    int n_checks;
    int n_errors;
    logic [DW-1:0] acc_q[$];

    typedef struct {
        int len_req;
        int eff_len;
        int gap_pct;
        int hold_cyc;
    } vec_t;
    vec_t tbl[10];

    shake_squeeze_collector #(.DATA_OUT_BITS(DW), .MAX_DIGEST_BITS(MDB)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len_words    (len_words),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] sw(input logic [DW-1:0] w);
`ifdef SQZ_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Expected digest: accepted words in order, slot i at bits [i*DW +: DW], rest zero.
    function automatic logic [MDB-1:0] model_digest();
        logic [MDB-1:0] m;
        m = '0;
        foreach (acc_q[i]) if (i < MAXW) m[i*DW +: DW] = sw(acc_q[i]);
        return m;
    endfunction

    task automatic check(input string name, input logic [MDB-1:0] act, input logic [MDB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, record handshake at posedge, return at next negedge.
    task automatic cyc(input logic v, input logic [DW-1:0] d);
        logic rdy;
        in_valid = v;
        data_in  = d;
        rdy      = in_ready;
        @(posedge clk);
        if (v && rdy) acc_q.push_back(d);
        @(negedge clk);
    endtask

    task automatic do_start(input int len_req);
        start     = 1'b1;
        len_words = CNT_W'(len_req);
        @(negedge clk);
        start     = 1'b0;
        len_words = CNT_W'($urandom_range(0, 31));
    endtask

    task automatic feed(input int target, input int gap_pct, input int det);
        int budget;
        budget = 0;
        while (acc_q.size() < target && budget < 400) begin
            if ($urandom_range(0, 99) >= gap_pct)
                cyc(1'b1, (det != 0) ? DW'(acc_q.size() + 1) : $urandom);
            else
                cyc(1'b0, $urandom);
            budget++;
        end
        in_valid = 1'b1;
        data_in  = $urandom;
    endtask

    task automatic finish_txn(input string name, input int exp_len, input int hold_cyc, input logic start_too);
        logic [MDB-1:0] exp_d;
        exp_d = model_digest();
        check({name, ".accepted"}, MDB'(acc_q.size()), MDB'(exp_len));
        check({name, ".in_ready_low"}, MDB'(in_ready), '0);
        check({name, ".valid_latency"}, MDB'(digest_valid), MDB'(1));
        check({name, ".busy_hold"}, MDB'(busy), MDB'(1));
        check({name, ".digest"}, digest, exp_d);
        for (int i = 0; i < hold_cyc; i++) begin
            cyc(1'b1, $urandom);
            check({name, ".hold_stable"}, digest, exp_d);
            check({name, ".hold_valid"}, MDB'({digest_valid, in_ready}), MDB'(2'b10));
        end
        digest_ready = 1'b1;
        start        = start_too;
        cyc(1'b1, $urandom);
        digest_ready = 1'b0;
        start        = 1'b0;
        check({name, ".release"}, MDB'({digest_valid, busy, in_ready}), '0);
        check({name, ".idle_digest"}, digest, exp_d);
        check({name, ".no_extra"}, MDB'(acc_q.size()), MDB'(exp_len));
        in_valid = 1'b0;
        $display("txn %s len=%0d accepted=%0d", name, exp_len, acc_q.size());
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        tbl[0] = '{8, 8, 0, 2};
        tbl[1] = '{2, 2, 50, 1};
        tbl[2] = '{0, 16, 30, 3};
        tbl[3] = '{20, 16, 40, 0};
        tbl[4] = '{16, 16, 0, 1};
        tbl[5] = '{1, 1, 60, 2};
        tbl[6] = '{17, 16, 20, 1};
        tbl[7] = '{15, 15, 70, 0};
        tbl[8] = '{5, 5, 10, 4};
        tbl[9] = '{31, 16, 50, 1};

        rst = 1'b1; start = 1'b0; len_words = '0; data_in = '0;
        in_valid = 1'b0; digest_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outputs", MDB'({in_ready, digest_valid, busy}), '0);
        check("reset.digest", digest, '0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.no_ready", MDB'({in_ready, busy}), '0);

        // T1: eight sequential words back-to-back, explicit digest.
        acc_q.delete();
        do_start(8);
        feed(8, 0, 1);
`ifdef SQZ_BYTESWAP_EN
        check("t1.const", digest, MDB'(256'h08000000_07000000_06000000_05000000_04000000_03000000_02000000_01000000));
`else
        check("t1.const", digest, MDB'(256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001));
`endif
        // T3: long hold, then a shorter fresh digest must clear stale words.
        finish_txn("t1", 8, 10, 1'b0);
        acc_q.delete();
        do_start(3);
        feed(3, 25, 0);
        finish_txn("t3", 3, 1, 1'b0);

        // T2: valid pattern 1,0,0,1 with valid held high afterwards.
        acc_q.delete();
        do_start(2);
        cyc(1'b1, 32'hA5A5_0001);
        cyc(1'b0, 32'hDEAD_BEEF);
        cyc(1'b0, 32'hDEAD_BEEF);
        cyc(1'b1, 32'hA5A5_0002);
        in_valid = 1'b1;
        data_in  = 32'hBAD0_BAD0;
        finish_txn("t2", 2, 2, 1'b0);

        // T4: start during COLLECT and with digest_ready in HOLD is ignored.
        acc_q.delete();
        do_start(4);
        feed(2, 0, 0);
        in_valid  = 1'b0;
        start     = 1'b1;
        len_words = CNT_W'(1);
        @(negedge clk);
        start = 1'b0;
        check("t4.busy_after_start", MDB'({busy, in_ready}), MDB'(2'b11));
        feed(4, 0, 0);
        finish_txn("t4", 4, 1, 1'b1);

        // T5: asynchronous reset after 3 of 8 words.
        acc_q.delete();
        do_start(8);
        feed(3, 0, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5.async_outputs", MDB'({in_ready, digest_valid, busy}), '0);
        check("t5.async_digest", digest, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        acc_q.delete();
        do_start(8);
        feed(8, 30, 0);
        finish_txn("t5", 8, 1, 1'b0);

        // Randomized table-driven transactions.
        foreach (tbl[i]) begin
            acc_q.delete();
            do_start(tbl[i].len_req);
            feed(tbl[i].eff_len, tbl[i].gap_pct, 0);
            finish_txn($sformatf("tbl%0d", i), tbl[i].eff_len, tbl[i].hold_cyc, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
